// File: rtl/prewish_button_events_pkg.sv
// Shared types for the button-event classifier: FSM states, event codes and
// the event-byte packing helper.
package prewish_button_events_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } state_e;

    localparam logic [1:0] EV_SHORT  = 2'b01;
    localparam logic [1:0] EV_LONG   = 2'b10;
    localparam logic [1:0] EV_DOUBLE = 2'b11;

    // Event byte layout: [7:4] sequence count, [3:2] zero, [1:0] event code.
    function automatic logic [7:0] pack_event(input logic [3:0] seq, input logic [1:0] code);
        return {seq, 2'b00, code};
    endfunction

endpackage

// File: rtl/prewish_button_events_tick_edge.sv
// Rising-edge detector for a slow divider level sampled in the system clock.
// One o_rise pulse per low-to-high transition of i_level.
module prewish_button_events_tick_edge (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_q;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/prewish_button_events.sv
// Classifies the debounced button level into SHORT / LONG / DOUBLE events timed
// by slow-clock ticks, emitting a one-cycle strobe plus a held event byte.
module prewish_button_events
    import prewish_button_events_pkg::*;
#(
    parameter int LONG_TICKS = 8,
    parameter int DBL_TICKS  = 3,
    parameter int CT_BITS    = 8
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    input  logic       i_tick,
    output logic       STB_O,
    output logic [7:0] DAT_O,
    output logic       o_busy
);

    localparam logic [CT_BITS-1:0] LONG_LAST = CT_BITS'(LONG_TICKS - 1);
    localparam logic [CT_BITS-1:0] DBL_LAST  = CT_BITS'(DBL_TICKS - 1);

    state_e             r_state;
    logic               r_press;
    logic [CT_BITS-1:0] r_cnt;
    logic [3:0]         r_seq;
    logic               r_stb;
    logic [7:0]         r_dat;
    logic               w_tick_rise;
    logic [3:0]         w_seq_next;
    logic               w_unused_dat;

    assign w_unused_dat = ^DAT_I[7:1];
    assign w_seq_next   = r_seq + 4'd1;

    prewish_button_events_tick_edge u_tick_edge (
        .i_clk   (CLK_I),
        .i_srst  (RST_I),
        .i_level (i_tick),
        .o_rise  (w_tick_rise)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= ST_IDLE;
            r_press <= 1'b0;
            r_cnt   <= '0;
            r_seq   <= '0;
            r_stb   <= 1'b0;
            r_dat   <= 8'h00;
        end else begin
            r_stb <= 1'b0;
            if (STB_I) begin
                r_press <= DAT_I[0];
            end

            // Level changes are checked before ticks so release/press win ties.
            unique case (r_state)
                ST_IDLE: begin
                    if (r_press) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESSED: begin
                    if (!r_press) begin
                        r_state <= ST_WAIT_SECOND;
                        r_cnt   <= '0;
                    end else if (w_tick_rise) begin
                        if (r_cnt == LONG_LAST) begin
                            r_state <= ST_LONG_HELD;
                            r_cnt   <= '0;
                            r_stb   <= 1'b1;
                            r_dat   <= pack_event(w_seq_next, EV_LONG);
                            r_seq   <= w_seq_next;
                        end else begin
                            r_cnt <= r_cnt + CT_BITS'(1);
                        end
                    end
                end
                ST_LONG_HELD: begin
                    if (!r_press) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_SECOND: begin
                    if (r_press) begin
                        r_state <= ST_SECOND_PRESSED;
                        r_cnt   <= '0;
                    end else if (w_tick_rise) begin
                        if (r_cnt == DBL_LAST) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_stb   <= 1'b1;
                            r_dat   <= pack_event(w_seq_next, EV_SHORT);
                            r_seq   <= w_seq_next;
                        end else begin
                            r_cnt <= r_cnt + CT_BITS'(1);
                        end
                    end
                end
                ST_SECOND_PRESSED: begin
                    if (!r_press) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_stb   <= 1'b1;
                        r_dat   <= pack_event(w_seq_next, EV_DOUBLE);
                        r_seq   <= w_seq_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign STB_O  = r_stb;
    assign DAT_O  = r_dat;
    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: doc/prewish_button_events.md
Name: prewish_button_events

Overview:
- Downstream consumer of prewish_debounce's status-byte strobe (STB_O/DAT_O).
- Classifies the debounced button level into SHORT, LONG and DOUBLE press events, timed by the slow divider clock.
- Emits each event as a one-cycle strobe plus an event byte for the blinky/command stage.
- Same strobe/data interconnect style as the rest of the prewish chain.

Parameters:
- LONG_TICKS, 8, slow-clock ticks a press must last to count as LONG; must be >= 1.
- DBL_TICKS, 3, slow-clock ticks after a release during which a second press makes a DOUBLE; must be >= 1.
- CT_BITS, 8, width of the tick counter; must hold max(LONG_TICKS, DBL_TICKS).

Ports:
- CLK_I  in  1  system clock; the only clock.
- RST_I  in  1  reset, synchronous, active-high.
- STB_I  in  1  status strobe from the debounce stage.
- DAT_I  in  8  status byte; bit0 = debounced pressed (1 = pressed); bits 7:1 ignored.
- i_tick  in  1  slow divider output (level), sampled in CLK_I; each rising edge is one tick.
- STB_O  out  1  one-cycle event strobe.
- DAT_O  out  8  event byte: [7:4] sequence count, [3:2] = 0, [1:0] event code.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (RST_I high at a CLK_I edge):
  - state = IDLE; press_q, tick_q, cnt, seq = 0.
  - STB_O = 0, DAT_O = 8'h00, o_busy = 0.
  - Reset mid-operation aborts any pending classification and emits no event.
- Input capture:
  - press_q <= DAT_I[0] on edges where STB_I = 1; holds otherwise.
  - The FSM acts on press_q, so its reaction is one cycle after the strobe edge.
- Tick detection:
  - tick_q <= i_tick every cycle; tick_rise = i_tick & ~tick_q.
  - Exactly one tick per low-to-high transition of i_tick.
- Event codes: 2'b01 SHORT, 2'b10 LONG, 2'b11 DOUBLE; 2'b00 is never emitted.
- Emitting an event at an edge:
  - STB_O = 1 for the following cycle only.
  - DAT_O = {seq+1, 2'b00, code}, held until the next event.
  - seq <= seq + 1, wrapping 15 -> 0. The first event after reset carries seq 1; the 16th carries seq 0.
- FSM (cnt cleared on every state entry):
  - IDLE: press_q = 1 -> PRESSED.
  - PRESSED:
    - press_q = 0 -> WAIT_SECOND.
    - else on tick_rise: if cnt == LONG_TICKS-1, emit LONG -> LONG_HELD; else cnt++.
    - Release and tick in the same cycle: release wins, no LONG.
  - LONG_HELD: press_q = 0 -> IDLE, no event; ticks ignored.
  - WAIT_SECOND:
    - press_q = 1 -> SECOND_PRESSED.
    - else on tick_rise: if cnt == DBL_TICKS-1, emit SHORT -> IDLE; else cnt++.
    - Press and final tick in the same cycle: press wins.
  - SECOND_PRESSED: press_q = 0 -> emit DOUBLE -> IDLE; ticks ignored; no long-press timeout.
- Latency: release strobe at edge N -> press_q changes at edge N -> transition (and any event registration) at edge N+1 -> STB_O high in the cycle after N+1.
- STB_I repeating the same level: no effect. STB_I during reset: ignored.
- o_busy is registered with state, i.e. (state != IDLE).

Decomposition:
- Shared include prewish_defs.vh holds:
  - event codes EV_SHORT/EV_LONG/EV_DOUBLE;
  - FSM state encodings (3 bits);
  - DAT_O field positions.
- One natural sub-module: prewish_tick_edge (tick_q register plus rising-edge pulse; reusable for any divider-driven stage).
- Everything else lives in one FSM module.

Test Plan:
- Reset held 15 cycles, no stimulus -> STB_O = 0, DAT_O = 8'h00, o_busy = 0 throughout.
- Press strobe, release after 2 ticks, no further press for 3 ticks -> exactly one STB_O pulse, DAT_O = 8'h11, o_busy back to 0.
- Press held for 8 ticks -> STB_O on the 8th tick_rise (+1 cycle), DAT_O = 8'h12; the later release produces no event.
- Press/release, second press within 2 ticks, release -> STB_O one cycle after release is registered, DAT_O = 8'h13; no SHORT emitted.
- Corner cases:
  - Release strobe coincident with the 8th tick_rise -> no LONG; a later timeout gives SHORT.
  - RST_I pulsed while in PRESSED -> no event, state IDLE.
- 17 consecutive SHORT events -> DAT_O[7:4] runs 1..15, 0, 1; code stays 01.
